// File: rtl/sift_pkg.sv
// Shared constants and types for the image downsampler.
// Default image geometry, pixel depth, BRAM latency, derived address widths
// and the pass-control FSM state type.
package sift_pkg;

  localparam int DS_SRC_WIDTH    = 128;
  localparam int DS_SRC_HEIGHT   = 128;
  localparam int DS_PIXEL_WIDTH  = 8;
  localparam int DS_BRAM_LATENCY = 2;

  localparam int DS_SRC_ADDR_W   = $clog2(DS_SRC_WIDTH * DS_SRC_HEIGHT);
  localparam int DS_DST_ADDR_W   = $clog2(DS_SRC_WIDTH * DS_SRC_HEIGHT / 4);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } ds_state_e;

  // Width of a counter able to index n items (at least one bit).
  function automatic int ds_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/downsample_accum.sv
// 4-sample accumulate/divide stage of the image downsampler.
// Consumes source pixels in groups of four (one 2x2 block), sums them in a
// PIXEL_WIDTH+2 accumulator and emits one registered destination write per
// block, destination addresses counting up from zero.
// Build option: DOWNSAMPLE_ROUND_EN selects (sum+2)>>2 instead of sum>>2.
module downsample_accum #(
  parameter int PIXEL_WIDTH = 8,
  parameter int DST_ADDR_W  = 12,
  parameter int N_OUT       = 4096
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   clear_in,
  input  logic                   sample_vld_in,
  input  logic [PIXEL_WIDTH-1:0] sample_in,
  output logic                   we_out,
  output logic [DST_ADDR_W-1:0]  addr_out,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   last_out
);

  localparam int ACC_W = PIXEL_WIDTH + 2;
  localparam logic [DST_ADDR_W-1:0] LAST_IDX = DST_ADDR_W'(N_OUT - 1);

  logic [1:0]             cnt_r;
  logic [ACC_W-1:0]       acc_r;
  logic [DST_ADDR_W-1:0]  out_idx_r;
  logic                   we_r;
  logic [DST_ADDR_W-1:0]  addr_r;
  logic [PIXEL_WIDTH-1:0] pix_r;
  logic                   last_r;

  logic [ACC_W-1:0]       sum_s;
  logic [ACC_W-1:0]       rnd_s;
  logic [PIXEL_WIDTH-1:0] avg_s;

  // Running sum including the incoming sample, and its divide-by-four.
  always_comb begin
    sum_s = acc_r + {2'b00, sample_in};
`ifdef DOWNSAMPLE_ROUND_EN
    rnd_s = sum_s + ACC_W'(2);
`else
    rnd_s = sum_s;
`endif
    avg_s = rnd_s[ACC_W-1:2];
  end

  // Accumulate four samples, then register one destination write.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cnt_r     <= 2'd0;
      acc_r     <= '0;
      out_idx_r <= '0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      pix_r     <= '0;
      last_r    <= 1'b0;
    end else if (clear_in) begin
      cnt_r     <= 2'd0;
      acc_r     <= '0;
      out_idx_r <= '0;
      we_r      <= 1'b0;
      last_r    <= 1'b0;
    end else if (sample_vld_in) begin
      if (cnt_r == 2'd3) begin
        cnt_r     <= 2'd0;
        acc_r     <= '0;
        we_r      <= 1'b1;
        addr_r    <= out_idx_r;
        pix_r     <= avg_s;
        last_r    <= (out_idx_r == LAST_IDX);
        out_idx_r <= out_idx_r + DST_ADDR_W'(1);
      end else begin
        cnt_r  <= cnt_r + 2'd1;
        acc_r  <= sum_s;
        we_r   <= 1'b0;
      end
    end else begin
      we_r <= 1'b0;
    end
  end

  assign we_out    = we_r;
  assign addr_out  = addr_r;
  assign pixel_out = pix_r;
  assign last_out  = last_r;

endmodule

// File: rtl/image_downsampler.sv
// 2x2 mean downsampler: reads a SRC_WIDTH x SRC_HEIGHT greyscale image from a
// source BRAM (one read per cycle, block-by-block in raster order of output
// pixels) and writes the half-resolution image to a destination BRAM.
// Build option: DOWNSAMPLE_ROUND_EN (round half up instead of truncating).
// BRAM_LATENCY must be at least 1.
module image_downsampler
  import sift_pkg::*;
#(
  parameter int SRC_WIDTH    = DS_SRC_WIDTH,
  parameter int SRC_HEIGHT   = DS_SRC_HEIGHT,
  parameter int PIXEL_WIDTH  = DS_PIXEL_WIDTH,
  parameter int BRAM_LATENCY = DS_BRAM_LATENCY
) (
  input  logic                                        clk_in,
  input  logic                                        rst_n_in,
  input  logic                                        start_in,
  output logic                                        busy_out,
  output logic                                        done_out,
  output logic [$clog2(SRC_WIDTH*SRC_HEIGHT)-1:0]     src_addr_out,
  input  logic [PIXEL_WIDTH-1:0]                      src_pixel_in,
  output logic [$clog2(SRC_WIDTH*SRC_HEIGHT/4)-1:0]   dst_addr_out,
  output logic [PIXEL_WIDTH-1:0]                      dst_pixel_out,
  output logic                                        dst_we_out
);

  localparam int SRC_ADDR_W = $clog2(SRC_WIDTH * SRC_HEIGHT);
  localparam int DST_ADDR_W = $clog2(SRC_WIDTH * SRC_HEIGHT / 4);
  localparam int OUT_W      = SRC_WIDTH / 2;
  localparam int OUT_H      = SRC_HEIGHT / 2;
  localparam int OX_W       = ds_cnt_w(OUT_W);
  localparam int OY_W       = ds_cnt_w(OUT_H);
  localparam logic [OX_W-1:0] OX_LAST = OX_W'(OUT_W - 1);
  localparam logic [OY_W-1:0] OY_LAST = OY_W'(OUT_H - 1);

  ds_state_e               state_r;
  ds_state_e               state_nxt_s;
  logic                    start_ok_s;
  logic                    last_read_s;

  logic [OX_W-1:0]         ox_r;
  logic [OY_W-1:0]         oy_r;
  logic [1:0]              sub_r;
  logic [SRC_ADDR_W-1:0]   addr_s;
  logic [SRC_ADDR_W-1:0]   src_addr_r;
  logic                    issue_r;
  logic [BRAM_LATENCY:1]   vld_sr_r;

  logic                    busy_r;
  logic                    done_r;

  logic                    acc_we_s;
  logic                    acc_last_s;
  logic [DST_ADDR_W-1:0]   acc_addr_s;
  logic [PIXEL_WIDTH-1:0]  acc_pix_s;

  // Current read position: sub_r[0] selects the column, sub_r[1] the row
  // inside the 2x2 block of output pixel (ox_r, oy_r).
  always_comb begin
    addr_s      = SRC_ADDR_W'({oy_r, sub_r[1]}) * SRC_ADDR_W'(SRC_WIDTH)
                + SRC_ADDR_W'({ox_r, sub_r[0]});
    last_read_s = (state_r == ST_READ) && (ox_r == OX_LAST) &&
                  (oy_r == OY_LAST) && (sub_r == 2'd3);
  end

  // Next-state logic; a start in the done cycle is deliberately dropped.
  always_comb begin
    state_nxt_s = state_r;
    start_ok_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_in && !done_r) begin
          start_ok_s  = 1'b1;
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (last_read_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (acc_we_s && acc_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Source address generator: one registered read per READ cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      ox_r       <= '0;
      oy_r       <= '0;
      sub_r      <= 2'd0;
      src_addr_r <= '0;
      issue_r    <= 1'b0;
    end else if (start_ok_s) begin
      ox_r       <= '0;
      oy_r       <= '0;
      sub_r      <= 2'd0;
      issue_r    <= 1'b0;
    end else if (state_r == ST_READ) begin
      src_addr_r <= addr_s;
      issue_r    <= 1'b1;
      sub_r      <= sub_r + 2'd1;
      if (sub_r == 2'd3) begin
        if (ox_r == OX_LAST) begin
          ox_r <= '0;
          oy_r <= oy_r + OY_W'(1);
        end else begin
          ox_r <= ox_r + OX_W'(1);
        end
      end
    end else begin
      issue_r <= 1'b0;
    end
  end

  // Delay the read-issue flag by the BRAM latency to mark valid read data.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      vld_sr_r <= '0;
    end else if (start_ok_s) begin
      vld_sr_r <= '0;
    end else begin
      vld_sr_r[1] <= issue_r;
      for (int i = 2; i <= BRAM_LATENCY; i++) begin
        vld_sr_r[i] <= vld_sr_r[i-1];
      end
    end
  end

  // Status flags: busy lags the state by one cycle so it covers the done cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_r != ST_IDLE);
      done_r <= (state_r == ST_DRAIN) && acc_we_s && acc_last_s;
    end
  end

  downsample_accum #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .DST_ADDR_W  (DST_ADDR_W),
    .N_OUT       (OUT_W * OUT_H)
  ) u_accum (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .clear_in      (start_ok_s),
    .sample_vld_in (vld_sr_r[BRAM_LATENCY]),
    .sample_in     (src_pixel_in),
    .we_out        (acc_we_s),
    .addr_out      (acc_addr_s),
    .pixel_out     (acc_pix_s),
    .last_out      (acc_last_s)
  );

  assign busy_out      = busy_r;
  assign done_out      = done_r;
  assign src_addr_out  = src_addr_r;
  assign dst_we_out    = acc_we_s;
  assign dst_addr_out  = acc_addr_s;
  assign dst_pixel_out = acc_pix_s;

endmodule

// File: tb/tb_image_downsampler.sv
// Scoreboard testbench for image_downsampler (default 128x128, 8-bit, latency 2).
// Expected reads/writes/timing are derived from the 2x2-mean definition and
// pushed into queues at start; a negedge monitor pops and compares.
module tb_image_downsampler;

  localparam int W        = 128;
  localparam int H        = 128;
  localparam int PW       = 8;
  localparam int L        = 2;
  localparam int N        = W * H;
  localparam int NO       = N / 4;
  localparam int AW       = $clog2(N);
  localparam int DW       = $clog2(NO);
  localparam int DONE_OFF = N + L + 2;
`ifdef DOWNSAMPLE_ROUND_EN
  localparam int EXP_BLK0 = 1;
`else
  localparam int EXP_BLK0 = 0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          start_in;
  logic          busy_out;
  logic          done_out;
  logic [AW-1:0] src_addr_out;
  logic [PW-1:0] src_pixel_in;
  logic [DW-1:0] dst_addr_out;
  logic [PW-1:0] dst_pixel_out;
  logic          dst_we_out;

  always #5 clk_in = ~clk_in;

  image_downsampler #(
    .SRC_WIDTH(W), .SRC_HEIGHT(H), .PIXEL_WIDTH(PW), .BRAM_LATENCY(L)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .start_in      (start_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .src_addr_out  (src_addr_out),
    .src_pixel_in  (src_pixel_in),
    .dst_addr_out  (dst_addr_out),
    .dst_pixel_out (dst_pixel_out),
    .dst_we_out    (dst_we_out)
  );

  // Source BRAM model with L cycles of read latency.
  logic [PW-1:0] mem [N];
  logic [AW-1:0] apipe [L];
  always @(posedge clk_in) begin
    apipe[0] <= src_addr_out;
    for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
  end
  assign src_pixel_in = mem[apipe[L-1]];

  typedef struct { int cyc; int addr; int pix; } wr_t;
  typedef struct { int cyc; int addr; } rd_t;
  wr_t wq[$];
  rd_t rq[$];

  int  edge_cnt = 0;
  int  e0 = 0;
  bit  pass_on = 1'b0;
  bit  mon_en = 1'b0;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_wr = 0;
  int  n_done = 0;
  int  cap [NO];

  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares status every cycle and pops scoreboard entries when due.
  always @(negedge clk_in) begin
    int  cur;
    bit  eb, ed, ew;
    wr_t w;
    rd_t r;
    if (mon_en) begin
      cur = edge_cnt;
      eb  = pass_on && (cur >= e0 + 1) && (cur <= e0 + DONE_OFF);
      ed  = pass_on && (cur == e0 + DONE_OFF);
      ew  = (wq.size() > 0) && (wq[0].cyc == cur);
      check("busy", busy_out, eb);
      check("done", done_out, ed);
      check("dst_we", dst_we_out, ew);
      if (done_out === 1'b1) n_done++;
      if (dst_we_out === 1'b1) n_wr++;
      if (ew) begin
        w = wq.pop_front();
        if (dst_we_out === 1'b1) begin
          check("dst_addr", dst_addr_out, w.addr);
          check("dst_pixel", dst_pixel_out, w.pix);
          cap[w.addr] = int'(dst_pixel_out);
        end
      end
      if ((rq.size() > 0) && (rq[0].cyc == cur)) begin
        r = rq.pop_front();
        check("src_addr", src_addr_out, r.addr);
      end
      if (ed) pass_on = 1'b0;
    end
  end

  task automatic check_reset_outputs();
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_we", dst_we_out, 0);
    check("rst_src_addr", src_addr_out, 0);
    check("rst_dst_addr", dst_addr_out, 0);
    check("rst_dst_pixel", dst_pixel_out, 0);
  endtask

  // Pulse start and load the scoreboard from the image in mem.
  task automatic start_pass();
    int sum, x, y, j;
    @(posedge clk_in); #1 start_in = 1'b1;
    @(posedge clk_in); #1 start_in = 1'b0;
    e0 = edge_cnt;
    for (int oy = 0; oy < H / 2; oy++) begin
      for (int ox = 0; ox < W / 2; ox++) begin
        j   = oy * (W / 2) + ox + 1;
        sum = 0;
        for (int s = 0; s < 4; s++) begin
          x = 2 * ox + (s % 2);
          y = 2 * oy + (s / 2);
          rq.push_back('{cyc: e0 + 4 * (j - 1) + s + 1, addr: y * W + x});
          sum += int'(mem[y * W + x]);
        end
`ifdef DOWNSAMPLE_ROUND_EN
        wq.push_back('{cyc: e0 + 4 * j + L + 1, addr: j - 1, pix: (sum + 2) / 4});
`else
        wq.push_back('{cyc: e0 + 4 * j + L + 1, addr: j - 1, pix: sum / 4});
`endif
      end
    end
    pass_on = 1'b1;
  endtask

  // Run until the pass ends; optionally inject starts that must be ignored.
  task automatic run_pass(input bit inject);
    int c;
    c = 0;
    while (pass_on && c < DONE_OFF + 40) begin
      @(posedge clk_in); #1;
      c = edge_cnt - e0;
      start_in = inject && (c == 10 || c == 16386 || c == DONE_OFF);
    end
    @(posedge clk_in); #1 start_in = 1'b0;
    if (pass_on) begin
      check("pass_timeout", 1, 0);
      pass_on = 1'b0;
    end
    wq.delete();
    rq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial begin
    int wr0;
    int c;
    rst_n_in = 1'b0;
    start_in = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    for (int i = 0; i < NO; i++) cap[i] = -1;
    repeat (3) @(posedge clk_in);
    #1 check_reset_outputs();
    rst_n_in = 1'b1;
    mon_en   = 1'b1;
    idle(5);

    // Pass 1: constant image, with starts that must all be ignored.
    for (int i = 0; i < N; i++) mem[i] = 8'd100;
    start_pass();
    run_pass(1'b1);
    idle(20);
    check("p1_write_count", n_wr, NO);
    check("p1_done_count", n_done, 1);

    // Aborted pass: one-cycle reset during cycle 5000.
    for (int i = 0; i < N; i++) mem[i] = PW'($urandom_range(0, 255));
    wr0 = n_wr;
    start_pass();
    c = 0;
    while (c < 5000) begin
      @(posedge clk_in); #1;
      c = edge_cnt - e0;
    end
    rst_n_in = 1'b0;
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    wq.delete();
    rq.delete();
    pass_on = 1'b0;
    check_reset_outputs();
    idle(200);
    check("abort_writes", n_wr - wr0, (5000 - L - 1) / 4);
    check("abort_done_count", n_done, 1);

    // Pass 2: random image with two hand-placed blocks.
    for (int i = 0; i < N; i++) mem[i] = PW'($urandom_range(0, 255));
    mem[0] = 8'd0;   mem[1] = 8'd0;   mem[W] = 8'd0;   mem[W + 1] = 8'd3;
    mem[2] = 8'd255; mem[3] = 8'd255; mem[W + 2] = 8'd255; mem[W + 3] = 8'd255;
    wr0 = n_wr;
    start_pass();
    run_pass(1'b0);
    idle(20);
    check("p2_write_count", n_wr - wr0, NO);
    check("p2_done_count", n_done, 2);
    check("blk_0003", cap[0], EXP_BLK0);
    check("blk_255", cap[1], 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
